// File: rtl/ts_tick_pkg.sv
// Shared state encodings and default sizing for the ts_tick_gen timed event generator.
package ts_tick_pkg;

   localparam int unsigned CNT_W_DEF      = 8;
   localparam int unsigned PRESCALE_DEF   = 10;
   localparam int unsigned TICK_LIMIT_DEF = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ts_prescaler.sv
// Enable-gated prescale counter with synchronous clear; wrap is a one-cycle
// combinational pulse on the cycle the count sits at PRESCALE-1.
module ts_prescaler import ts_tick_pkg::*; #(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned PRESCALE = PRESCALE_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;

   // next count: clear wins over enable, terminal count folds back to zero
   always_comb begin
      count_d = count_q;
      wrap    = 1'b0;
      if (clr) begin
         count_d = {CNT_W{1'b0}};
      end else if (en) begin
         if (count_q == LAST) begin
            count_d = {CNT_W{1'b0}};
            wrap    = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end else begin
         count_d = count_q;
      end
   end

   // count register
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ts_tick_gen.sv
// Timed event generator: prescaled ticks counted to a limit, then a held done/ack handshake.
// Optional build macro TS_TICK_GEN_LOAD_EN adds a per-run limit_in port.
module ts_tick_gen import ts_tick_pkg::*; #(
   parameter int unsigned PRESCALE   = PRESCALE_DEF,
   parameter int unsigned TICK_LIMIT = TICK_LIMIT_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             ack,
`ifdef TS_TICK_GEN_LOAD_EN
   input  logic [CNT_W-1:0] limit_in,
`endif
   output logic             tick,
   output logic [CNT_W-1:0] tick_count,
   output logic             busy,
   output logic             done
);

   state_e           state_d, state_q;
   logic             tick_d, tick_q;
   logic             busy_d, busy_q;
   logic             done_d, done_q;
   logic [CNT_W-1:0] count_d, count_q;
   logic [CNT_W-1:0] count_inc;
   logic [CNT_W-1:0] run_limit;
   logic             ps_en;
   logic             ps_clr;
   logic             ps_wrap;

   assign ps_en     = (state_q == ST_RUN);
   assign ps_clr    = ~ps_en;
   assign count_inc = count_q + CNT_W'(1);

   ts_prescaler #(
      .CNT_W    (CNT_W),
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clock (clock),
      .reset (reset),
      .clr   (ps_clr),
      .en    (ps_en),
      .wrap  (ps_wrap)
   );

`ifdef TS_TICK_GEN_LOAD_EN
   logic [CNT_W-1:0] limit_d, limit_q;

   // per-run limit captured on the IDLE->RUN edge; zero is promoted to one
   always_comb begin
      limit_d = limit_q;
      if ((state_q == ST_IDLE) && start) begin
         limit_d = (limit_in == {CNT_W{1'b0}}) ? CNT_W'(1) : limit_in;
      end else begin
         limit_d = limit_q;
      end
   end

   // limit register
   always_ff @(posedge clock) begin
      if (reset) begin
         limit_q <= CNT_W'(1);
      end else begin
         limit_q <= limit_d;
      end
   end

   assign run_limit = limit_q;
`else
   assign run_limit = CNT_W'(TICK_LIMIT);
`endif

   // FSM next state and next output values
   always_comb begin
      state_d = state_q;
      tick_d  = 1'b0;
      busy_d  = busy_q;
      done_d  = done_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               count_d = {CNT_W{1'b0}};
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (ps_wrap) begin
               tick_d  = 1'b1;
               count_d = count_inc;
               // >= keeps the count from ever passing the limit
               if (count_inc >= run_limit) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (ack) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   assign tick       = tick_q;
   assign tick_count = count_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_ts_tick_gen.sv
// Self-checking bench for ts_tick_gen: tick timing is scoreboarded through a queue of
// expected (edge, tick_count) pairs pushed at start and popped on each observed tick.
module tb_ts_tick_gen;

   logic       clock = 1'b0;
   logic       reset, start, ack, start1, ack1;
   logic       tick, busy, done, tick1, busy1, done1;
   logic [7:0] tick_count, tick_count1;
`ifdef TS_TICK_GEN_LOAD_EN
   logic [7:0] limit_in, limit_in1;
`endif

   int passed = 0;
   int total  = 0;

   typedef struct {
      int         edge_n;
      logic [7:0] cnt;
   } exp_t;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   ts_tick_gen dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .ack        (ack),
`ifdef TS_TICK_GEN_LOAD_EN
      .limit_in   (limit_in),
`endif
      .tick       (tick),
      .tick_count (tick_count),
      .busy       (busy),
      .done       (done)
   );

   ts_tick_gen #(.PRESCALE(1), .TICK_LIMIT(3), .CNT_W(8)) dut1 (
      .clock      (clock),
      .reset      (reset),
      .start      (start1),
      .ack        (ack1),
`ifdef TS_TICK_GEN_LOAD_EN
      .limit_in   (limit_in1),
`endif
      .tick       (tick1),
      .tick_count (tick_count1),
      .busy       (busy1),
      .done       (done1)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; ack = 1'b0; start1 = 1'b0; ack1 = 1'b0;
`ifdef TS_TICK_GEN_LOAD_EN
      limit_in = 8'd10; limit_in1 = 8'd3;
`endif
      repeat (3) step();
      total++;
      if ({tick, busy, done, tick_count} !== 11'd0)
         $display("FAIL reset_state: got %h want 0", {tick, busy, done, tick_count});
      else passed++;
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         total++;
         if ({tick, busy, done, tick_count, tick1, busy1, done1, tick_count1} !== 22'd0)
            $display("FAIL idle_quiet cycle %0d: got %h want 0", i,
                     {tick, busy, done, tick_count, tick1, busy1, done1, tick_count1});
         else passed++;
      end
   endtask

   task automatic test_default_run();
      exp_t e;
      for (int k = 1; k <= 10; k++) exp_q.push_back('{edge_n: 10 * k, cnt: 8'(k)});
      start = 1'b1; step(); start = 1'b0;
      total++;
      if (busy !== 1'b1 || tick_count !== 8'd0 || done !== 1'b0)
         $display("FAIL run_entry: got busy=%b cnt=%0d done=%b want 1 0 0", busy, tick_count, done);
      else passed++;
      for (int n = 1; n <= 110; n++) begin
         step();
         if (tick === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_tick: got tick at edge %0d want none", n);
            end else begin
               e = exp_q.pop_front();
               if (n != e.edge_n || tick_count !== e.cnt)
                  $display("FAIL tick_timing: got edge %0d cnt %0d want edge %0d cnt %0d",
                           n, tick_count, e.edge_n, e.cnt);
               else passed++;
            end
         end
         total++;
         if (busy !== (n < 100) || done !== (n >= 100))
            $display("FAIL busy_done edge %0d: got busy=%b done=%b want %b %b",
                     n, busy, done, (n < 100), (n >= 100));
         else passed++;
         start = (n == 50);
      end
      total++;
      if (exp_q.size() != 0) begin
         $display("FAIL missing_ticks: got %0d unseen want 0", exp_q.size());
         exp_q.delete();
      end else passed++;
      total++;
      if (tick_count !== 8'd10)
         $display("FAIL final_count: got %0d want 10", tick_count);
      else passed++;
   endtask

   task automatic test_done_hold();
      for (int i = 0; i < 50; i++) begin
         step();
         total++;
         if (done !== 1'b1 || tick !== 1'b0 || busy !== 1'b0 || tick_count !== 8'd10)
            $display("FAIL done_held cycle %0d: got done=%b tick=%b busy=%b cnt=%0d want 1 0 0 10",
                     i, done, tick, busy, tick_count);
         else passed++;
      end
      ack = 1'b1; start = 1'b1; step(); ack = 1'b0; start = 1'b0;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || tick_count !== 8'd10)
         $display("FAIL ack_release: got done=%b busy=%b cnt=%0d want 0 0 10", done, busy, tick_count);
      else passed++;
      for (int i = 0; i < 20; i++) begin
         step();
         total++;
         if (busy !== 1'b0 || done !== 1'b0 || tick !== 1'b0 || tick_count !== 8'd10)
            $display("FAIL start_dropped cycle %0d: got busy=%b done=%b tick=%b cnt=%0d want 0 0 0 10",
                     i, busy, done, tick, tick_count);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      for (int k = 1; k <= 4; k++) exp_q.push_back('{edge_n: 10 * k, cnt: 8'(k)});
      start = 1'b1; step(); start = 1'b0;
      for (int n = 1; n <= 44; n++) begin
         step();
         if (tick === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_tick_mid: got tick at edge %0d want none", n);
            end else begin
               e = exp_q.pop_front();
               if (n != e.edge_n || tick_count !== e.cnt)
                  $display("FAIL tick_timing_mid: got edge %0d cnt %0d want edge %0d cnt %0d",
                           n, tick_count, e.edge_n, e.cnt);
               else passed++;
            end
         end
      end
      reset = 1'b1; step(); reset = 1'b0;
      total++;
      if ({tick, busy, done, tick_count} !== 11'd0 || exp_q.size() != 0)
         $display("FAIL mid_reset: got %h pending %0d want 0 0", {tick, busy, done, tick_count}, exp_q.size());
      else passed++;
      exp_q.delete();
      exp_q.push_back('{edge_n: 10, cnt: 8'd1});
      start = 1'b1; step(); start = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         step();
         if (tick === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_tick_restart: got tick at edge %0d want none", n);
            end else begin
               e = exp_q.pop_front();
               if (n != e.edge_n || tick_count !== e.cnt)
                  $display("FAIL restart_tick: got edge %0d cnt %0d want edge %0d cnt %0d",
                           n, tick_count, e.edge_n, e.cnt);
               else passed++;
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         $display("FAIL restart_missing: got %0d unseen want 0", exp_q.size());
         exp_q.delete();
      end else passed++;
      reset = 1'b1; step(); reset = 1'b0;
   endtask

   task automatic test_prescale_one();
      exp_t e;
      for (int k = 1; k <= 3; k++) exp_q.push_back('{edge_n: k, cnt: 8'(k)});
      start1 = 1'b1; step(); start1 = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         step();
         if (tick1 === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_tick_p1: got tick at edge %0d want none", n);
            end else begin
               e = exp_q.pop_front();
               if (n != e.edge_n || tick_count1 !== e.cnt)
                  $display("FAIL tick_p1: got edge %0d cnt %0d want edge %0d cnt %0d",
                           n, tick_count1, e.edge_n, e.cnt);
               else passed++;
            end
         end
         total++;
         if (busy1 !== (n < 3) || done1 !== (n >= 3))
            $display("FAIL busy_done_p1 edge %0d: got busy=%b done=%b want %b %b",
                     n, busy1, done1, (n < 3), (n >= 3));
         else passed++;
      end
      total++;
      if (exp_q.size() != 0) begin
         $display("FAIL missing_ticks_p1: got %0d unseen want 0", exp_q.size());
         exp_q.delete();
      end else passed++;
      ack1 = 1'b1; step(); ack1 = 1'b0;
      total++;
      if (done1 !== 1'b0 || tick_count1 !== 8'd3)
         $display("FAIL ack_p1: got done=%b cnt=%0d want 0 3", done1, tick_count1);
      else passed++;
   endtask

`ifdef TS_TICK_GEN_LOAD_EN
   task automatic test_load_en();
      exp_t e;
      for (int k = 1; k <= 4; k++) exp_q.push_back('{edge_n: 10 * k, cnt: 8'(k)});
      limit_in = 8'd4; start = 1'b1; step(); start = 1'b0;
      for (int n = 1; n <= 50; n++) begin
         step();
         if (tick === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_tick_load: got tick at edge %0d want none", n);
            end else begin
               e = exp_q.pop_front();
               if (n != e.edge_n || tick_count !== e.cnt)
                  $display("FAIL tick_load: got edge %0d cnt %0d want edge %0d cnt %0d",
                           n, tick_count, e.edge_n, e.cnt);
               else passed++;
            end
         end
         total++;
         if (done !== (n >= 40))
            $display("FAIL done_load edge %0d: got %b want %b", n, done, (n >= 40));
         else passed++;
         if (n == 20) limit_in = 8'd9;
      end
      total++;
      if (exp_q.size() != 0) begin
         $display("FAIL missing_ticks_load: got %0d unseen want 0", exp_q.size());
         exp_q.delete();
      end else passed++;
      ack = 1'b1; step(); ack = 1'b0;
      limit_in = 8'd0; start = 1'b1; step(); start = 1'b0;
      for (int n = 1; n <= 15; n++) begin
         step();
         total++;
         if (done !== (n >= 10) || tick !== (n == 10))
            $display("FAIL zero_limit edge %0d: got done=%b tick=%b want %b %b",
                     n, done, tick, (n >= 10), (n == 10));
         else passed++;
      end
      total++;
      if (tick_count !== 8'd1)
         $display("FAIL zero_limit_count: got %0d want 1", tick_count);
      else passed++;
      ack = 1'b1; step(); ack = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_default_run();
      test_done_hold();
      test_reset_mid_run();
      test_prescale_one();
`ifdef TS_TICK_GEN_LOAD_EN
      test_load_en();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
